hlsm_launcher: RTL and testbench

Initiator for the Start/Done handshake of our generated HLSM datapath cores. It buffers one operand vector from an upstream valid/ready stream and launches the core with a single-cycle `core_start` pulse. It waits for `core_done`, with a timeout, then captures the core's result vector and presents it downstream on a valid/ready stream. It sits between the streaming fabric and one HLSM instance, and keeps exactly one job in flight.

---
 rtl/hlsm_launcher.sv | 125 ++++++++++++
 tb/tb_hlsm_launcher.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hlsm_launcher.sv
// Start/Done initiator for one HLSM datapath core: buffers one operand vector,
// launches the core, waits for Done (with timeout) and streams the result out.
module hlsm_launcher #(
  parameter int DATA_W  = 16,
  parameter int N_IN    = 8,
  parameter int N_OUT   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  output logic                    core_start,
  output logic [N_IN*DATA_W-1:0]  core_opnd,
  input  logic                    core_done,
  input  logic [N_OUT*DATA_W-1:0] core_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [7:0]              job_cnt
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    pending;
  logic [N_IN*DATA_W-1:0]  opnd_buf;
  logic [TW-1:0]           timer;
  logic                    accept;
  logic                    drain;
  logic                    launch;
  logic                    capture;
  logic                    abort;

  // in_ready depends only on the pending register, never on in_valid
  assign in_ready   = !pending;
  assign accept     = in_valid && !pending;
  assign drain      = out_valid && out_ready;
  assign core_start = (state == LAUNCH);
  assign busy       = (state != IDLE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        // The result slot must be empty or emptying this cycle before launch
        if (pending && (!out_valid || out_ready)) begin
          launch     = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: state_next = WAIT;
      WAIT: begin
        if (core_done) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pending     <= 1'b0;
      opnd_buf    <= '0;
      core_opnd   <= '0;
      timer       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      timeout_err <= 1'b0;
      job_cnt     <= 8'd0;
    end else begin
      if (accept) begin
        opnd_buf <= in_data;
        pending  <= 1'b1;
      end else if (launch) begin
        pending  <= 1'b0;
      end

      if (launch) begin
        core_opnd <= opnd_buf;
      end

      if (state == LAUNCH) begin
        timer <= '0;
      end else if (state == WAIT && !core_done) begin
        timer <= timer + TW'(1);
      end

      if (capture) begin
        out_data  <= core_res;
        out_valid <= 1'b1;
        job_cnt   <= job_cnt + 8'd1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end

      if (abort) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hlsm_launcher.sv
// Bench for hlsm_launcher: table vectors, directed corner sequences and a
// randomized stream checked against a result-queue reference model.
module tb_hlsm_launcher;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         core_start;
  logic [127:0] core_opnd;
  logic         core_done;
  logic [63:0]  core_res;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         busy;
  logic         timeout_err;
  logic [7:0]   job_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hlsm_launcher #(.DATA_W(16), .N_IN(8), .N_OUT(4), .TIMEOUT(8)) dut (
    .Clk(clk), .Rst(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_start(core_start), .core_opnd(core_opnd),
    .core_done(core_done), .core_res(core_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .timeout_err(timeout_err), .job_cnt(job_cnt)
  );

  // Reference result: pairwise signed products, low 16 bits kept
  function automatic logic [63:0] prod(input logic [127:0] v);
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [31:0] p;
    logic [63:0]        r;
    r = '0;
    for (int w = 0; w < 4; w++) begin
      x = v[32*w +: 16];
      y = v[32*w+16 +: 16];
      p = x * y;
      r[16*w +: 16] = p[15:0];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Core model: Done one cycle, 4 cycles after the Start cycle
  logic [2:0]   core_cnt = 3'd0;
  logic [127:0] core_lat = '0;
  logic         core_en;
  logic         spur;
  always @(posedge clk) begin
    if (core_start) begin
      core_cnt <= 3'd4;
      core_lat <= core_opnd;
    end else if (core_cnt != 3'd0) begin
      core_cnt <= core_cnt - 3'd1;
    end
  end
  assign core_done = (core_en && core_cnt == 3'd1) || spur;
  assign core_res  = prod(core_lat);

  // Scoreboard: every accepted vector owes one result, in order
  logic [63:0]  q[$];
  int           pops = 0;
  logic         prev_start = 1'b0;
  logic         prev_busy = 1'b0;
  logic [127:0] prev_opnd = '0;
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      pops = 0;
      prev_start = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else chk("stream_data", out_data, q.pop_front());
        pops++;
      end
      if (in_valid && in_ready) q.push_back(prod(in_data));
      if (core_start) chk("start_gap", prev_start, 0);
      if (busy && prev_busy) chk("opnd_stable", core_opnd, prev_opnd);
      prev_start = core_start;
      prev_busy  = busy;
      prev_opnd  = core_opnd;
    end
  end

  task automatic wait_quiet();
    int n;
    n = 0;
    @(negedge clk);
    while (!(in_ready && !busy && !out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("quiet_timeout", 0, 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("out_timeout", 0, 1);
  endtask

  typedef struct {
    logic [127:0] din;
    logic [63:0]  dout;
  } vec_t;

  vec_t         tbl[4];
  logic [127:0] bp[3];
  logic [63:0]  held;
  logic [7:0]   jc;
  int           lat;
  int           idx;
  int           starts;
  int           first_start;
  bit           acc;
  bit           have_held;
  bit           held_ok;
  bit           stale_bad;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0].din  = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2};
    tbl[0].dout = {16'd72, 16'd42, 16'd20, 16'd6};
    tbl[1].din  = {96'h0, 16'h0007, 16'hFFFD};
    tbl[1].dout = {48'h0, 16'hFFEB};
    tbl[2].din  = {16'h0100, 16'h0100, 16'h0001, 16'hFFFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF};
    tbl[2].dout = {16'h0000, 16'hFFFF, 16'h0000, 16'h0001};
    tbl[3].din  = {16'hFFFC, 16'h0003, 16'hFFF0, 16'h0010, 16'h0000, 16'h1234, 16'hFFFB, 16'hFFFE};
    tbl[3].dout = {16'hFFF4, 16'hFF00, 16'h0000, 16'h000A};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    core_en = 1'b1; spur = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outs", {core_start, out_valid, busy, timeout_err, job_cnt}, 0);
    chk("rst_data", {core_opnd, out_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: launch at c+2, result at c+7
    for (int i = 0; i < 4; i++) begin
      wait_quiet();
      in_valid = 1'b1; in_data = tbl[i].din;
      @(negedge clk);
      in_valid = 1'b0;
      chk("start_c1", core_start, 0);
      @(negedge clk);
      chk("start_c2", core_start, 1);
      wait_out(lat);
      chk("latency", lat + 2, 7);
      chk("tbl_out_data", out_data, tbl[i].dout);
      chk("tbl_core_opnd", core_opnd, tbl[i].din);
      chk("tbl_job_cnt", job_cnt, i + 1);
    end

    // Backpressure: one launch, second vector buffered, result held
    wait_quiet();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) bp[i] = rand128();
    idx = 0; starts = 0; have_held = 0; held_ok = 1; held = '0;
    in_valid = 1'b1; in_data = bp[0];
    for (int k = 0; k < 20; k++) begin
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) in_data = bp[idx];
        else in_valid = 1'b0;
      end
      if (core_start) starts++;
      if (out_valid) begin
        if (!have_held) begin held = out_data; have_held = 1; end
        else if (out_data !== held) held_ok = 0;
      end
    end
    chk("bp_launches", starts, 1);
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_held_data", held, prod(bp[0]));
    chk("bp_held_stable", held_ok, 1);
    out_ready = 1'b1;
    first_start = -1;
    for (int k = 0; k < 100; k++) begin
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) in_data = bp[idx];
        else in_valid = 1'b0;
      end
      if (core_start && first_start < 0) first_start = k + 1;
      if (idx == 3 && q.size() == 0 && !busy && !out_valid) break;
    end
    chk("bp_relaunch_delay", first_start, 1);
    chk("bp_drained", q.size(), 0);
    chk("bp_job_cnt", job_cnt, 7);

    // Spurious done while idle
    wait_quiet();
    jc = job_cnt;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_out_valid", out_valid, 0);
    chk("spur_job_cnt", job_cnt, jc);
    chk("spur_busy", busy, 0);

    // Timeout: abort on 8th WAIT cycle, next job still completes
    wait_quiet();
    core_en = 1'b0;
    jc = job_cnt;
    in_valid = 1'b1; in_data = rand128();
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("to_start", core_start, 1);
    repeat (8) @(negedge clk);
    chk("to_busy_8th", busy, 1);
    chk("to_err_before", timeout_err, 0);
    @(negedge clk);
    chk("to_err_set", timeout_err, 1);
    chk("to_busy_drop", busy, 0);
    chk("to_no_out", out_valid, 0);
    chk("to_job_cnt", job_cnt, jc);
    if (q.size() > 0) void'(q.pop_front());
    core_en = 1'b1;
    wait_quiet();
    in_valid = 1'b1; in_data = tbl[2].din;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    chk("to_next_data", out_data, tbl[2].dout);
    chk("to_next_cnt", job_cnt, jc + 8'd1);
    chk("to_err_sticky", timeout_err, 1);

    // Reset mid-WAIT with a previous result still in out_data
    wait_quiet();
    in_valid = 1'b1; in_data = tbl[0].din;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {core_start, out_valid, busy, timeout_err, job_cnt}, 0);
    chk("mid_rst_data", {core_opnd, out_data}, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale_bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || busy) stale_bad = 1;
    end
    chk("stale_done_ignored", stale_bad, 0);
    chk("stale_job_cnt", job_cnt, 0);

    // Randomized stream against the scoreboard
    for (int k = 0; k < 3000; k++) begin
      acc = in_valid && in_ready;
      @(negedge clk);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(9) < 6);
        in_data  = rand128();
      end
      out_ready = ($urandom_range(9) < 7);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_quiet();
    @(negedge clk);
    chk("rand_drained", q.size(), 0);
    chk("rand_job_cnt", job_cnt, pops[7:0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
